decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, meaning the width of the program counter carried alongside each instruction.
REQ-002 The block SHALL have parameter ALU_OP_W, default 5, meaning the width of the alu_op output code.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-005 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_instr (input, 32) and in_pc (input, PC_W), forming the upstream instruction handshake.
REQ-006 The block SHALL have port flush, input, 1, which discards every buffered instruction.
REQ-007 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the downstream handshake.
REQ-008 The block SHALL have decoded outputs: out_pc (PC_W), rd/rs1/rs2 (5 each), imm (32), alu_op (ALU_OP_W), reg_write, mem_read, mem_write, mem_to_reg, mem_size (3, funct3), branch, br_cond (3, funct3), jal, jalr, use_imm, use_pc, illegal (1 each).

Function
REQ-009 The block SHALL decode the full RV32I base set: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
REQ-010 Immediates SHALL be sign-extended per format: I, S, B (bit0=0), U (low 12 bits zero), J (bit0=0); shift-immediates SHALL be zero-extended instr[24:20].
REQ-011 The alu_op codes SHALL be ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASS_B=10.
REQ-012 The following SHALL decode with alu_op=ADD: LOAD, STORE, JALR, JAL, AUIPC (AUIPC also sets use_pc=1); LUI SHALL use PASS_B; BRANCH SHALL use SUB with branch=1.
REQ-013 The block SHALL assert illegal for: unknown opcode; an OP funct7/funct3 pair outside the ISA; a shift-immediate with bad funct7; LOAD funct3 in {3,6,7}; STORE funct3>2; BRANCH funct3 in {2,3}; JALR funct3!=0.
REQ-014 When illegal=1, reg_write, mem_read, mem_write, branch, jal and jalr SHALL all be 0, and the instruction SHALL still pass downstream.
REQ-015 The pipeline SHALL be a 2-entry skid buffer with states EMPTY, ONE and FULL; decoding happens at input and the registered result appears one cycle after acceptance.
REQ-016 in_ready SHALL equal (state!=FULL), driven from a register with no combinational path from out_ready.
REQ-017 State transitions SHALL be: accept-only increments; pop-only (out_valid&&out_ready) decrements; simultaneous accept and pop holds the state, with FIFO ordering preserved.
REQ-018 out_valid SHALL equal (state!=EMPTY), and the outputs SHALL stay stable while out_valid&&!out_ready.
REQ-019 flush SHALL force EMPTY on the next edge, ignore a same-cycle in_valid, and have priority over all other events.

Reset
REQ-020 rst SHALL force state EMPTY, out_valid=0 and in_ready=1 (deasserted only after the first edge following reset release), and set every decoded output to 0.
REQ-021 A reset asserted mid-transfer SHALL drop all buffered entries with no partial output.

Configuration
REQ-022 When DECODE_STAGE_RV32M_EN is defined, OP with funct7=0000001 SHALL decode MUL..REMU to alu_op 11..18 in funct3 order.
REQ-023 When DECODE_STAGE_RV32M_EN is undefined, OP with funct7=0000001 SHALL be illegal.

Structure
REQ-024 A shared package decode_pkg SHALL hold the opcode constants, alu_op constants, and the struct of decoded fields.
REQ-025 A combinational sub-module decode_comb SHALL map (instr, pc) to that struct; decode_stage SHALL hold the skid buffer.

Verification
REQ-026 The bench SHALL drive 0xFFF00093 (addi x1,x0,-1) and check imm=0xFFFFFFFF, alu_op=0, rd=1, use_imm=1, reg_write=1, output one cycle later.
REQ-027 The bench SHALL drive 0x402081B3 (sub) -> alu_op=1, rs1=1, rs2=2, rd=3; and 0x123452B7 (lui) -> imm=0x12345000, alu_op=10.
REQ-028 The bench SHALL drive 0x00208463 (beq +8) -> branch=1, br_cond=0, imm=8, reg_write=0; and 0x0000007F -> illegal=1, all enables 0.
REQ-029 The bench SHALL hold out_ready=0 and stream 3 instructions, checking in_ready=0 after 2, then release and check in-order delivery with none lost.
REQ-030 The bench SHALL assert flush while FULL with in_valid=1, checking out_valid=0 next cycle and that the flushed-cycle instruction never appears.
REQ-031 The bench SHALL drive 0x023100B3 (mul) and check alu_op=11 with DECODE_STAGE_RV32M_EN defined, and illegal=1 without it.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the RV32I decode stage.
//   - RV32I major opcode constants
//   - alu_op code constants (ADD..PASS_B, plus MUL..REMU codes 11..18)
//   - dec_t: the packed record of decoded fields produced by decode_comb
//   - buf_state_e: occupancy states of the decode_stage skid buffer
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int unsigned ALU_OP_BITS = 5;

  localparam logic [ALU_OP_BITS-1:0] ALU_ADD    = 5'd0;
  localparam logic [ALU_OP_BITS-1:0] ALU_SUB    = 5'd1;
  localparam logic [ALU_OP_BITS-1:0] ALU_XOR    = 5'd2;
  localparam logic [ALU_OP_BITS-1:0] ALU_OR     = 5'd3;
  localparam logic [ALU_OP_BITS-1:0] ALU_AND    = 5'd4;
  localparam logic [ALU_OP_BITS-1:0] ALU_SLL    = 5'd5;
  localparam logic [ALU_OP_BITS-1:0] ALU_SRL    = 5'd6;
  localparam logic [ALU_OP_BITS-1:0] ALU_SRA    = 5'd7;
  localparam logic [ALU_OP_BITS-1:0] ALU_SLT    = 5'd8;
  localparam logic [ALU_OP_BITS-1:0] ALU_SLTU   = 5'd9;
  localparam logic [ALU_OP_BITS-1:0] ALU_PASS_B = 5'd10;
  // MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU follow as 11..18
  localparam logic [ALU_OP_BITS-1:0] ALU_MUL    = 5'd11;

  typedef struct packed {
    logic [4:0]             rd;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [31:0]            imm;
    logic [ALU_OP_BITS-1:0] alu_op;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic                   mem_to_reg;
    logic [2:0]             mem_size;
    logic                   branch;
    logic [2:0]             br_cond;
    logic                   jal;
    logic                   jalr;
    logic                   use_imm;
    logic                   use_pc;
    logic                   illegal;
  } dec_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I instruction decoder.
//   instr [31:0]  : raw instruction word
//   pc    [PC_W]  : program counter of the instruction (passed through)
//   dec   dec_t   : decoded fields
//   pc_o  [PC_W]  : pc aligned with dec
// Build option: define DECODE_STAGE_RV32M_EN to decode the RV32M OP group
// (funct7=0000001) as alu_op 11..18; otherwise that group is illegal.
// Illegal encodings keep their raw register fields and immediate but carry
// alu_op=ADD and no side-effect enables.
module decode_comb
  import decode_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc,
  output dec_t            dec,
  output logic [PC_W-1:0] pc_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic        bad;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  assign pc_o = pc;

  always_comb begin
    dec     = '0;
    dec.rd  = instr[11:7];
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    bad     = 1'b0;

    unique case (opcode)
      OPC_LUI: begin
        dec.imm       = imm_u;
        dec.alu_op    = ALU_PASS_B;
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm       = imm_u;
        dec.alu_op    = ALU_ADD;
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.use_pc    = 1'b1;
      end
      OPC_JAL: begin
        dec.imm       = imm_j;
        dec.alu_op    = ALU_ADD;
        dec.reg_write = 1'b1;
        dec.jal       = 1'b1;
        dec.use_imm   = 1'b1;
      end
      OPC_JALR: begin
        dec.imm       = imm_i;
        dec.alu_op    = ALU_ADD;
        dec.reg_write = 1'b1;
        dec.jalr      = 1'b1;
        dec.use_imm   = 1'b1;
        bad           = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        dec.imm     = imm_b;
        dec.alu_op  = ALU_SUB;
        dec.branch  = 1'b1;
        dec.br_cond = funct3;
        bad         = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_LOAD: begin
        dec.imm        = imm_i;
        dec.alu_op     = ALU_ADD;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.mem_size   = funct3;
        dec.use_imm    = 1'b1;
        bad            = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        dec.imm       = imm_s;
        dec.alu_op    = ALU_ADD;
        dec.mem_write = 1'b1;
        dec.mem_size  = funct3;
        dec.use_imm   = 1'b1;
        bad           = (funct3 > 3'd2);
      end
      OPC_OP_IMM: begin
        dec.imm       = imm_i;
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        unique case (funct3)
          3'd0: dec.alu_op = ALU_ADD;
          3'd2: dec.alu_op = ALU_SLT;
          3'd3: dec.alu_op = ALU_SLTU;
          3'd4: dec.alu_op = ALU_XOR;
          3'd6: dec.alu_op = ALU_OR;
          3'd7: dec.alu_op = ALU_AND;
          3'd1: begin
            dec.imm    = imm_sh;
            dec.alu_op = ALU_SLL;
            bad        = (funct7 != 7'b0000000);
          end
          default: begin // funct3 = 5: SRLI / SRAI
            dec.imm = imm_sh;
            if (funct7 == 7'b0000000)      dec.alu_op = ALU_SRL;
            else if (funct7 == 7'b0100000) dec.alu_op = ALU_SRA;
            else                           bad        = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
        unique case (funct7)
          7'b0000000: begin
            unique case (funct3)
              3'd0:    dec.alu_op = ALU_ADD;
              3'd1:    dec.alu_op = ALU_SLL;
              3'd2:    dec.alu_op = ALU_SLT;
              3'd3:    dec.alu_op = ALU_SLTU;
              3'd4:    dec.alu_op = ALU_XOR;
              3'd5:    dec.alu_op = ALU_SRL;
              3'd6:    dec.alu_op = ALU_OR;
              default: dec.alu_op = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'd0)      dec.alu_op = ALU_SUB;
            else if (funct3 == 3'd5) dec.alu_op = ALU_SRA;
            else                     bad        = 1'b1;
          end
          7'b0000001: begin
`ifdef DECODE_STAGE_RV32M_EN
            dec.alu_op = ALU_MUL + {2'b00, funct3};
`else
            bad = 1'b1;
`endif
          end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      dec.alu_op     = ALU_ADD;
      dec.reg_write  = 1'b0;
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.branch     = 1'b0;
      dec.jal        = 1'b0;
      dec.jalr       = 1'b0;
    end
    dec.illegal = bad;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode pipeline stage with a 2-entry skid buffer.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake carrying in_instr, in_pc
//   flush               : drop every buffered instruction (highest priority)
//   out_valid/out_ready : downstream handshake for the decoded record
//   out_pc, rd, rs1, rs2, imm, alu_op, reg_write, mem_read, mem_write,
//   mem_to_reg, mem_size, branch, br_cond, jal, jalr, use_imm, use_pc,
//   illegal             : registered decode of the head entry
// Build option: DECODE_STAGE_RV32M_EN enables RV32M decode in decode_comb.
// Decoding happens at the input; the head register drives the outputs
// directly, and in_ready/out_valid are flops so neither handshake has a
// combinational path through the other.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned ALU_OP_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_W-1:0]     in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [31:0]         imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic [2:0]          mem_size,
  output logic                branch,
  output logic [2:0]          br_cond,
  output logic                jal,
  output logic                jalr,
  output logic                use_imm,
  output logic                use_pc,
  output logic                illegal
);

  dec_t            dec;
  logic [PC_W-1:0] dec_pc;

  decode_comb #(
    .PC_W(PC_W)
  ) u_decode_comb (
    .instr(in_instr),
    .pc   (in_pc),
    .dec  (dec),
    .pc_o (dec_pc)
  );

  buf_state_e      state_q, state_d;
  dec_t            head_q, head_d, tail_q, tail_d;
  logic [PC_W-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            accept, pop;

  assign accept = in_valid && in_ready_q;
  assign pop    = out_valid_q && out_ready;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    head_pc_d = head_pc_q;
    tail_pc_d = tail_pc_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_d    = dec;
            head_pc_d = dec_pc;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          // Simultaneous accept+pop replaces the head in place; accept-only
          // parks the newcomer behind the head.
          if (accept && pop) begin
            head_d    = dec;
            head_pc_d = dec_pc;
          end else if (accept) begin
            tail_d    = dec;
            tail_pc_d = dec_pc;
            state_d   = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_d    = tail_q;
            head_pc_d = tail_pc_q;
            state_d   = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      head_pc_q   <= '0;
      tail_pc_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      head_pc_q   <= head_pc_d;
      tail_pc_q   <= tail_pc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_pc     = head_pc_q;
  assign rd         = head_q.rd;
  assign rs1        = head_q.rs1;
  assign rs2        = head_q.rs2;
  assign imm        = head_q.imm;
  assign alu_op     = ALU_OP_W'(head_q.alu_op);
  assign reg_write  = head_q.reg_write;
  assign mem_read   = head_q.mem_read;
  assign mem_write  = head_q.mem_write;
  assign mem_to_reg = head_q.mem_to_reg;
  assign mem_size   = head_q.mem_size;
  assign branch     = head_q.branch;
  assign br_cond    = head_q.br_cond;
  assign jal        = head_q.jal;
  assign jalr       = head_q.jalr;
  assign use_imm    = head_q.use_imm;
  assign use_pc     = head_q.use_pc;
  assign illegal    = head_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, backpressure / flush /
// mid-transfer reset sequences, and a randomized run against a queue-based
// reference of the buffer plus an arithmetic reference decoder.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [4:0]  rd, rs1, rs2, alu_op;
  logic        reg_write, mem_read, mem_write, mem_to_reg;
  logic [2:0]  mem_size, br_cond;
  logic        branch, jal, jalr, use_imm, use_pc, illegal;

  always #5 clk = ~clk;

  decode_stage #(.PC_W(32), .ALU_OP_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_op(alu_op),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .mem_size(mem_size), .branch(branch),
    .br_cond(br_cond), .jal(jal), .jalr(jalr), .use_imm(use_imm),
    .use_pc(use_pc), .illegal(illegal)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [2:0]  mem_size;
    logic        branch;
    logic [2:0]  br_cond;
    logic        jal;
    logic        jalr;
    logic        use_imm;
    logic        use_pc;
    logic        illegal;
  } exp_t;

  typedef struct packed {
    exp_t        f;
    logic [31:0] pc;
  } sb_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        exp;
  } vec_t;

  exp_t act;
  assign act = {rd, rs1, rs2, imm, alu_op, reg_write, mem_read, mem_write, mem_to_reg,
                mem_size, branch, br_cond, jal, jalr, use_imm, use_pc, illegal};

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  sb_t         q[$];
  logic [31:0] delivered[$];
  bit          last_acc;

  // ALU code of the RV32I register-register group by funct3 (funct7=0)
  int base_alu[8] = '{0, 5, 8, 9, 2, 6, 3, 4};

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    int  alu;
    bit  legal;
    e = '0;
    opc = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    e.rd = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    alu = 0;
    legal = 1'b1;
    case (opc)
      7'h37: begin e.imm = ins & 32'hFFFFF000; alu = 10; e.reg_write = 1; e.use_imm = 1; end
      7'h17: begin e.imm = ins & 32'hFFFFF000; e.reg_write = 1; e.use_imm = 1; e.use_pc = 1; end
      7'h6F: begin
        e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) << 1;
        e.reg_write = 1; e.jal = 1; e.use_imm = 1;
      end
      7'h67: begin
        e.imm = 32'($signed(ins[31:20])); e.reg_write = 1; e.jalr = 1; e.use_imm = 1;
        legal = (f3 == 0);
      end
      7'h63: begin
        e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) << 1;
        alu = 1; e.branch = 1; e.br_cond = f3;
        legal = !(f3 inside {3'd2, 3'd3});
      end
      7'h03: begin
        e.imm = 32'($signed(ins[31:20])); e.reg_write = 1; e.mem_read = 1;
        e.mem_to_reg = 1; e.mem_size = f3; e.use_imm = 1;
        legal = !(f3 inside {3'd3, 3'd6, 3'd7});
      end
      7'h23: begin
        e.imm = 32'($signed({ins[31:25], ins[11:7]})); e.mem_write = 1;
        e.mem_size = f3; e.use_imm = 1;
        legal = (f3 <= 2);
      end
      7'h13: begin
        e.reg_write = 1; e.use_imm = 1;
        alu = base_alu[f3];
        if (f3 == 1 || f3 == 5) begin
          e.imm = {27'd0, ins[24:20]};
          if (f3 == 5 && f7 == 7'h20) alu = 7;
          else if (f7 != 0) legal = 0;
        end else begin
          e.imm = 32'($signed(ins[31:20]));
        end
      end
      7'h33: begin
        e.reg_write = 1;
        if (f7 == 0) alu = base_alu[f3];
        else if (f7 == 7'h20 && f3 == 0) alu = 1;
        else if (f7 == 7'h20 && f3 == 5) alu = 7;
`ifdef DECODE_STAGE_RV32M_EN
        else if (f7 == 7'h01) alu = 11 + int'(f3);
`endif
        else legal = 0;
      end
      default: legal = 0;
    endcase
    if (!legal) begin
      alu = 0;
      e.illegal = 1; e.reg_write = 0; e.mem_read = 0; e.mem_write = 0;
      e.mem_to_reg = 0; e.branch = 0; e.jal = 0; e.jalr = 0;
    end
    e.alu_op = 5'(alu);
    return e;
  endfunction

  task automatic check_sb();
    bit bad;
    bad = 0;
    n_vec++;
    if (in_ready !== (q.size() < 2)) begin
      $display("FAIL in_ready: got %b want %b", in_ready, (q.size() < 2)); bad = 1;
    end
    if (out_valid !== (q.size() > 0)) begin
      $display("FAIL out_valid: got %b want %b", out_valid, (q.size() > 0)); bad = 1;
    end
    if (q.size() > 0 && out_valid === 1'b1) begin
      if (act !== q[0].f || out_pc !== q[0].pc) begin
        $display("FAIL head_fields: got %h pc %h want %h pc %h", act, out_pc, q[0].f, q[0].pc);
        bad = 1;
      end
    end
    if (bad) n_err++;
  endtask

  // Drive one cycle of inputs, advance the reference, then check at negedge.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    sb_t s;
    bit  pp;
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    last_acc = iv && (q.size() < 2) && !fl;
    pp = ordy && (q.size() > 0);
    if (fl) begin
      q.delete();
    end else begin
      if (pp) begin
        delivered.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (last_acc) begin
        s.f = ref_decode(ins);
        s.pc = pc;
        q.push_back(s);
      end
    end
    @(negedge clk);
    check_sb();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] opcs[9];
    int unsigned k;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) r[6:0] = opcs[k];
    if (r[6:0] == 7'h33 || (r[6:0] == 7'h13 && r[13:12] == 2'b01)) begin
      k = $urandom_range(0, 3);
      if (k == 0) r[31:25] = 7'h00;
      else if (k == 1) r[31:25] = 7'h20;
      else if (k == 2) r[31:25] = 7'h01;
    end
    return r;
  endfunction

  vec_t tbl[9];

  initial begin
    tbl[0].instr = 32'hFFF00093;
    tbl[0].exp = exp_t'{rd:5'd1, rs1:5'd0, rs2:5'd31, imm:32'hFFFFFFFF, alu_op:5'd0,
                        reg_write:1'b1, use_imm:1'b1, default:'0};
    tbl[1].instr = 32'h402081B3;
    tbl[1].exp = exp_t'{rd:5'd3, rs1:5'd1, rs2:5'd2, alu_op:5'd1, reg_write:1'b1, default:'0};
    tbl[2].instr = 32'h123452B7;
    tbl[2].exp = exp_t'{rd:5'd5, rs1:5'd8, rs2:5'd3, imm:32'h12345000, alu_op:5'd10,
                        reg_write:1'b1, use_imm:1'b1, default:'0};
    tbl[3].instr = 32'h00208463;
    tbl[3].exp = exp_t'{rd:5'd8, rs1:5'd1, rs2:5'd2, imm:32'd8, alu_op:5'd1,
                        branch:1'b1, br_cond:3'd0, default:'0};
    tbl[4].instr = 32'h0000007F;
    tbl[4].exp = exp_t'{illegal:1'b1, default:'0};
    tbl[5].instr = 32'h0040A103;
    tbl[5].exp = exp_t'{rd:5'd2, rs1:5'd1, rs2:5'd4, imm:32'd4, reg_write:1'b1, mem_read:1'b1,
                        mem_to_reg:1'b1, mem_size:3'd2, use_imm:1'b1, default:'0};
    tbl[6].instr = 32'h0020A223;
    tbl[6].exp = exp_t'{rd:5'd4, rs1:5'd1, rs2:5'd2, imm:32'd4, mem_write:1'b1,
                        mem_size:3'd2, use_imm:1'b1, default:'0};
    tbl[7].instr = 32'h023100B3;
`ifdef DECODE_STAGE_RV32M_EN
    tbl[7].exp = exp_t'{rd:5'd1, rs1:5'd2, rs2:5'd3, alu_op:5'd11, reg_write:1'b1, default:'0};
`else
    tbl[7].exp = exp_t'{rd:5'd1, rs1:5'd2, rs2:5'd3, illegal:1'b1, default:'0};
`endif
    // lw with funct3=3 is reserved: illegal, enables cleared
    tbl[8].instr = 32'h0040B103;
    tbl[8].exp = exp_t'{rd:5'd2, rs1:5'd1, rs2:5'd4, imm:32'd4, mem_size:3'd3,
                        use_imm:1'b1, illegal:1'b1, default:'0};

    rst = 1'b1; in_valid = 0; in_instr = '0; in_pc = '0; flush = 0; out_ready = 0;
    #12;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || act !== '0 || out_pc !== '0) begin
      $display("FAIL reset_state: ov %b ir %b fields %h pc %h want ov 0 ir 1 all zero",
               out_valid, in_ready, act, out_pc);
      n_err++;
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed table: each vector appears one cycle after acceptance.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, tbl[i].instr, 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
      n_vec++;
      if (out_valid !== 1'b1 || act !== tbl[i].exp) begin
        $display("FAIL table[%0d]: ov %b got %h want %h", i, out_valid, act, tbl[i].exp);
        n_err++;
      end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end

    // Backpressure: third instruction stalls until the buffer drains.
    delivered.delete();
    step(1'b1, 32'h00100093, 32'hA0, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 32'hA4, 1'b0, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0) begin
      $display("FAIL full_in_ready: got %b want 0", in_ready); n_err++;
    end
    step(1'b1, 32'h00300193, 32'hA8, 1'b0, 1'b0);
    step(1'b1, 32'h00300193, 32'hA8, 1'b0, 1'b0);
    begin
      bit cacc = 0;
      for (int i = 0; i < 8; i++) begin
        step(!cacc, 32'h00300193, 32'hA8, 1'b1, 1'b0);
        if (last_acc) cacc = 1;
      end
    end
    n_vec++;
    if (delivered.size() != 3 || delivered[0] != 32'hA0 || delivered[1] != 32'hA4 ||
        delivered[2] != 32'hA8) begin
      $display("FAIL backpressure_order: got %0d entries first %h want A0,A4,A8",
               delivered.size(), (delivered.size() > 0) ? delivered[0] : 32'h0);
      n_err++;
    end

    // Flush while FULL with a same-cycle in_valid.
    delivered.delete();
    step(1'b1, 32'h00400213, 32'hB0, 1'b0, 1'b0);
    step(1'b1, 32'h00500293, 32'hB4, 1'b0, 1'b0);
    step(1'b1, 32'h00600313, 32'hB8, 1'b1, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL flush_out_valid: got %b want 0", out_valid); n_err++;
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_vec++;
    if (delivered.size() != 0) begin
      $display("FAIL flush_leak: got %0d delivered first %h want 0", delivered.size(), delivered[0]);
      n_err++;
    end

    // Reset asserted while two entries are buffered.
    step(1'b1, 32'h00700393, 32'hC0, 1'b0, 1'b0);
    step(1'b1, 32'h00800413, 32'hC4, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || act !== '0 || out_pc !== '0) begin
      $display("FAIL midreset: ov %b ir %b fields %h pc %h want ov 0 ir 1 all zero",
               out_valid, in_ready, act, out_pc);
      n_err++;
    end
    q.delete();
    in_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic against the reference queue.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
